// File: rtl/ysyx_23060184_sram_axi_slave_pkg.sv
// ysyx_23060184_sram_axi_slave_pkg: response codes, SRAM address window and channel FSM encodings
package ysyx_23060184_sram_axi_slave_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [31:0] SRAM_ADDR_BEGIN = 32'h8000_0000;
    localparam logic [31:0] SRAM_ADDR_END   = 32'h8000_1000;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_e;
endpackage

// File: rtl/ysyx_23060184_sram_array.sv
// ysyx_23060184_sram_array: word-addressed RAM, synchronous byte-masked write, combinational read
module ysyx_23060184_sram_array
    import ysyx_23060184_sram_axi_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IW = $clog2(DEPTH_WORDS)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [IW-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [IW-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk)
        if (we)
            for (int i = 0; i < DATA_WIDTH/8; i++)
                if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];

    assign rdata = mem[raddr];
endmodule

// File: rtl/ysyx_23060184_sram_axi_slave.sv
// ysyx_23060184_sram_axi_slave: AXI4-lite SRAM responder with independent read/write FSMs
// and programmable response latency.
module ysyx_23060184_sram_axi_slave
    import ysyx_23060184_sram_axi_slave_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ACERR_WIDTH = 2,
    parameter int DEPTH_WORDS = int'((SRAM_ADDR_END - SRAM_ADDR_BEGIN) >> 2),
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR = SRAM_ADDR_BEGIN,
    parameter int RD_LATENCY  = 1,
    parameter int WR_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [DATA_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    aready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ACERR_WIDTH-1:0]  rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [DATA_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic                    bvalid,
    output logic [ACERR_WIDTH-1:0]  bresp,
    input  logic                    bready
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(RD_LATENCY > WR_LATENCY ? RD_LATENCY : WR_LATENCY) + 1;
    localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(4 * DEPTH_WORDS);

    r_state_e rstate;
    w_state_e wstate;
    logic [CW-1:0] rcnt, wcnt;
    logic [DATA_WIDTH-1:0] raddr_q, waddr_q, wdata_q, rd_addr, r_off, w_off, ram_rdata, r_sample;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic [ACERR_WIDTH-1:0] r_resp_n;
    logic r_hit, w_hit, commit, aw_have, w_have;

    // With single-cycle latency the RAM is sampled on the AR handshake itself, straight from araddr.
    assign rd_addr  = rstate == R_IDLE ? araddr : raddr_q;
    assign r_off    = rd_addr - BASE_ADDR;
    assign w_off    = waddr_q - BASE_ADDR;
    assign r_hit    = r_off < SPAN;
    assign w_hit    = w_off < SPAN;
    assign r_sample = r_hit ? ram_rdata : '0;
    assign r_resp_n = r_hit ? ACERR_WIDTH'(RESP_OKAY) : ACERR_WIDTH'(RESP_DECERR);
    assign commit   = wstate == W_WAIT && wcnt == '0 && w_hit;
    assign aw_have  = !awready || awvalid;
    assign w_have   = !wready || wvalid;

    ysyx_23060184_sram_array #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk  (clk),
        .we   (commit),
        .wstrb(wstrb_q),
        .waddr(IW'(w_off >> 2)),
        .wdata(wdata_q),
        .raddr(IW'(r_off >> 2)),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rstate  <= R_IDLE;
            aready  <= 1'b1;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= '0;
            rcnt    <= '0;
            raddr_q <= '0;
        end else begin
            case (rstate)
                R_IDLE: if (arvalid && aready) begin
                    raddr_q <= araddr;
                    aready  <= 1'b0;
                    rcnt    <= CW'(RD_LATENCY - 1);
                    if (RD_LATENCY == 1) begin
                        rdata  <= r_sample;
                        rresp  <= r_resp_n;
                        rvalid <= 1'b1;
                        rstate <= R_RESP;
                    end else rstate <= R_WAIT;
                end
                R_WAIT: if (rcnt == '0) begin
                    rdata  <= r_sample;
                    rresp  <= r_resp_n;
                    rvalid <= 1'b1;
                    rstate <= R_RESP;
                end else rcnt <= rcnt - 1'b1;
                R_RESP: if (rready) begin
                    rvalid <= 1'b0;
                    aready <= 1'b1;
                    rstate <= R_IDLE;
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // AW and W are captured independently; each ready drops on its own handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate  <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b1;
            bvalid  <= 1'b0;
            bresp   <= '0;
            wcnt    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        waddr_q <= awaddr;
                        awready <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                        wready  <= 1'b0;
                    end
                    if (aw_have && w_have) begin
                        wcnt   <= CW'(WR_LATENCY - 1);
                        wstate <= W_WAIT;
                    end
                end
                W_WAIT: if (wcnt == '0) begin
                    bresp  <= w_hit ? ACERR_WIDTH'(RESP_OKAY) : ACERR_WIDTH'(RESP_DECERR);
                    bvalid <= 1'b1;
                    wstate <= W_RESP;
                end else wcnt <= wcnt - 1'b1;
                W_RESP: if (bready) begin
                    bvalid  <= 1'b0;
                    awready <= 1'b1;
                    wready  <= 1'b1;
                    wstate  <= W_IDLE;
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060184_sram_axi_slave.sv
// tb_ysyx_23060184_sram_axi_slave: directed vector table plus multi-cycle corner sequences
// against a 1/1-latency instance (index 0) and a 4/3-latency instance (index 1).
module tb_ysyx_23060184_sram_axi_slave;
    logic clk, resetn;
    logic [31:0] araddr [2], rdata [2], awaddr [2], wdata [2];
    logic [3:0]  wstrb [2];
    logic [1:0]  rresp [2], bresp [2];
    logic arvalid [2], aready [2], rvalid [2], rready [2];
    logic awvalid [2], awready [2], wvalid [2], wready [2], bvalid [2], bready [2];
    int total = 0, bad = 0;

    ysyx_23060184_sram_axi_slave #(.RD_LATENCY(1), .WR_LATENCY(1)) dut0 (
        .clk(clk), .resetn(resetn),
        .araddr(araddr[0]), .arvalid(arvalid[0]), .aready(aready[0]),
        .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
        .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
        .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
        .bvalid(bvalid[0]), .bresp(bresp[0]), .bready(bready[0])
    );

    ysyx_23060184_sram_axi_slave #(.RD_LATENCY(4), .WR_LATENCY(3)) dut1 (
        .clk(clk), .resetn(resetn),
        .araddr(araddr[1]), .arvalid(arvalid[1]), .aready(aready[1]),
        .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
        .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
        .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
        .bvalid(bvalid[1]), .bresp(bresp[1]), .bready(bready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic rd(input int d, input logic [31:0] a, input int stall, input bit pre,
                      output logic [31:0] dat, output logic [1:0] resp, output int lat,
                      output bit stable, output logic [1:0] post);
        @(negedge clk);
        araddr[d] = a; arvalid[d] = 1'b1; rready[d] = pre;
        @(negedge clk);
        arvalid[d] = 1'b0;
        lat = 0;
        while (!rvalid[d] && lat < 20) begin @(negedge clk); lat++; end
        dat = rdata[d]; resp = rresp[d]; stable = 1'b1;
        repeat (stall) begin
            @(negedge clk);
            if (rvalid[d] !== 1'b1 || rdata[d] !== dat || rresp[d] !== resp) stable = 1'b0;
        end
        rready[d] = 1'b1;
        @(negedge clk);
        post = {aready[d], rvalid[d]};
        rready[d] = 1'b0;
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                      input int lead, input int stall, input bit pre,
                      output logic [1:0] resp, output int lat, output logic [1:0] rdy,
                      output bit stable, output logic [2:0] post);
        @(negedge clk);
        wdata[d] = dat; wstrb[d] = s; wvalid[d] = 1'b1; bready[d] = pre;
        if (lead > 0) begin
            @(negedge clk);
            wvalid[d] = 1'b0;
            repeat (lead - 1) @(negedge clk);
        end
        rdy = {awready[d], wready[d]};
        awaddr[d] = a; awvalid[d] = 1'b1;
        @(negedge clk);
        awvalid[d] = 1'b0; wvalid[d] = 1'b0;
        lat = 0;
        while (!bvalid[d] && lat < 20) begin @(negedge clk); lat++; end
        resp = bresp[d]; stable = 1'b1;
        repeat (stall) begin
            @(negedge clk);
            if (bvalid[d] !== 1'b1 || bresp[d] !== resp) stable = 1'b0;
        end
        bready[d] = 1'b1;
        @(negedge clk);
        post = {awready[d], wready[d], bvalid[d]};
        bready[d] = 1'b0;
    endtask

    typedef struct {
        int d; bit wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb;
        int lead; int stall; bit pre; logic [31:0] exp; logic [1:0] resp; int lat;
    } vec_t;

    initial begin
        vec_t v [18];
        logic [31:0] dat;
        logic [1:0] resp, rdy, post2;
        logic [2:0] post3;
        int lat;
        bit stable, seen;
        v = '{
            '{0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 32'h0,         2'd0, 1},
            '{0, 0, 32'h8000_0010, 32'h0,         4'h0, 0, 0, 0, 32'hDEAD_BEEF, 2'd0, 0},
            '{0, 1, 32'h8000_0010, 32'h1122_3344, 4'h5, 0, 0, 0, 32'h0,         2'd0, 1},
            '{0, 0, 32'h8000_0012, 32'h0,         4'h0, 0, 0, 0, 32'hDE22_BE44, 2'd0, 0},
            '{0, 1, 32'h8000_0000, 32'h0102_0304, 4'hF, 0, 0, 0, 32'h0,         2'd0, 1},
            '{0, 0, 32'h1000_0000, 32'h0,         4'h0, 0, 0, 0, 32'h0,         2'd3, 0},
            '{0, 1, 32'h1000_0000, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 32'h0,         2'd3, 1},
            '{0, 0, 32'h8000_0000, 32'h0,         4'h0, 0, 0, 0, 32'h0102_0304, 2'd0, 0},
            '{0, 0, 32'h8000_1000, 32'h0,         4'h0, 0, 0, 0, 32'h0,         2'd3, 0},
            '{0, 0, 32'h7FFF_FFFC, 32'h0,         4'h0, 0, 0, 0, 32'h0,         2'd3, 0},
            '{0, 1, 32'h8000_0FFC, 32'h1234_5678, 4'hF, 0, 0, 1, 32'h0,         2'd0, 1},
            '{0, 0, 32'h8000_0FFC, 32'h0,         4'h0, 0, 0, 1, 32'h1234_5678, 2'd0, 0},
            '{0, 1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 32'h0,         2'd0, 1},
            '{0, 0, 32'h8000_0010, 32'h0,         4'h0, 0, 0, 0, 32'hDE22_BE44, 2'd0, 0},
            '{1, 1, 32'h8000_0040, 32'h0BAD_F00D, 4'hF, 2, 5, 0, 32'h0,         2'd0, 3},
            '{1, 0, 32'h8000_0040, 32'h0,         4'h0, 0, 5, 0, 32'h0BAD_F00D, 2'd0, 4},
            '{1, 0, 32'h1000_0000, 32'h0,         4'h0, 0, 0, 0, 32'h0,         2'd3, 4},
            '{0, 1, 32'h8000_0020, 32'h0,         4'hF, 0, 0, 0, 32'h0,         2'd0, 1}
        };
        resetn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            araddr[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b0;
            awaddr[d] = '0; awvalid[d] = 1'b0; wdata[d] = '0; wstrb[d] = '0;
            wvalid[d] = 1'b0; bready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_ctl", d), 32'({aready[d], awready[d], wready[d], rvalid[d], bvalid[d]}), 32'b11100);
            chk($sformatf("rst%0d_data", d), rdata[d], 32'h0);
            chk($sformatf("rst%0d_resp", d), 32'({rresp[d], bresp[d]}), 32'h0);
        end
        resetn = 1'b1;
        @(negedge clk);
        chk("rel_ctl", 32'({aready[0], awready[0], wready[0], rvalid[0], bvalid[0]}), 32'b11100);

        for (int i = 0; i < 18; i++) begin
            if (v[i].wr) begin
                wr(v[i].d, v[i].addr, v[i].data, v[i].strb, v[i].lead, v[i].stall, v[i].pre,
                   resp, lat, rdy, stable, post3);
                chk($sformatf("v%0d_bresp", i), 32'(resp), 32'(v[i].resp));
                chk($sformatf("v%0d_blat", i), lat, v[i].lat);
                chk($sformatf("v%0d_rdy", i), 32'(rdy), v[i].lead > 0 ? 32'b10 : 32'b11);
                chk($sformatf("v%0d_bpost", i), 32'(post3), 32'b110);
            end else begin
                rd(v[i].d, v[i].addr, v[i].stall, v[i].pre, dat, resp, lat, stable, post2);
                chk($sformatf("v%0d_rdata", i), dat, v[i].exp);
                chk($sformatf("v%0d_rresp", i), 32'(resp), 32'(v[i].resp));
                chk($sformatf("v%0d_rlat", i), lat, v[i].lat);
                chk($sformatf("v%0d_rpost", i), 32'(post2), 32'b10);
            end
            if (v[i].stall > 0) chk($sformatf("v%0d_stable", i), 32'(stable), 32'h1);
        end

        // read sample and write commit hit the same word on the same edge
        @(negedge clk);
        awaddr[0] = 32'h8000_0020; wdata[0] = 32'hA5A5_A5A5; wstrb[0] = 4'hF;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        @(negedge clk);
        awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        araddr[0] = 32'h8000_0020; arvalid[0] = 1'b1;
        @(negedge clk);
        arvalid[0] = 1'b0;
        chk("same_rvalid", 32'(rvalid[0]), 32'h1);
        chk("same_bvalid", 32'(bvalid[0]), 32'h1);
        chk("same_old", rdata[0], 32'h0);
        rready[0] = 1'b1; bready[0] = 1'b1;
        @(negedge clk);
        rready[0] = 1'b0; bready[0] = 1'b0;
        rd(0, 32'h8000_0020, 0, 0, dat, resp, lat, stable, post2);
        chk("same_new", dat, 32'hA5A5_A5A5);

        // reset while dut0 sits in W_RESP and dut1 in R_WAIT
        @(negedge clk);
        araddr[1] = 32'h8000_0040; arvalid[1] = 1'b1;
        awaddr[0] = 32'h8000_0030; wdata[0] = 32'h600D_CAFE; wstrb[0] = 4'hF;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        @(negedge clk);
        arvalid[1] = 1'b0; awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        @(negedge clk);
        chk("mid_bvalid", 32'(bvalid[0]), 32'h1);
        chk("mid_aready", 32'(aready[1]), 32'h0);
        #2 resetn = 1'b0;
        #1;
        chk("rst_bvalid", 32'(bvalid[0]), 32'h0);
        chk("rst_rvalid", 32'(rvalid[1]), 32'h0);
        chk("rst_readies", 32'({awready[0], wready[0], aready[1]}), 32'b111);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid[1] || bvalid[0]) seen = 1'b1;
        end
        chk("rst_dropped", 32'(seen), 32'h0);
        chk("rst_rel_readies", 32'({awready[0], wready[0], aready[0], aready[1]}), 32'b1111);
        rd(0, 32'h8000_0030, 0, 0, dat, resp, lat, stable, post2);
        chk("rst_keep0", dat, 32'h600D_CAFE);
        rd(0, 32'h8000_0010, 0, 0, dat, resp, lat, stable, post2);
        chk("rst_keep1", dat, 32'hDE22_BE44);
        rd(1, 32'h8000_0040, 0, 0, dat, resp, lat, stable, post2);
        chk("rst_keep2", dat, 32'h0BAD_F00D);
        chk("rst_keep2_lat", lat, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
